sequence_player: RTL

- Downstream consumer of the game's speed-scaled timeout pulse.
- Holds the current memory sequence of 2-bit symbols and plays it back on the LEDs, one symbol per timeout period, with a blank gap after each symbol.
- Drives the timer's enable for the duration of playback.
- Signals completion to the game controller so it can start the player-input phase.

---
 rtl/sequence_player.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sequence_player.sv
// Plays a stored sequence of 2-bit symbols on one-hot LEDs, one symbol
// per timer period followed by a blank gap, then pulses done.
module sequence_player #(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = 4,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [1:0]       wr_data,
    input  logic [LEN_W-1:0] seq_len,
    input  logic             start,
    input  logic             abort,
    input  logic             timeout,
    output logic             timer_en,
    output logic [3:0]       leds,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] play_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mem_q [MAX_LEN];
    logic [3:0]       leds_q, leds_d;
    logic             timer_en_q, timer_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] rd_addr;
    logic [1:0]       rd_sym;
    logic             last;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Write-through so a same-cycle write to the next symbol is displayed.
    assign rd_addr = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
    assign rd_sym  = (wr_en && wr_addr == rd_addr) ? wr_data : mem_q[rd_addr];
    assign last    = ({1'b0, idx_q} == len_q - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        leds_d     = leds_q;
        timer_en_d = timer_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        len_d      = len_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (seq_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = SHOW;
                        idx_d      = '0;
                        leds_d     = 4'b0001 << rd_sym;
                        timer_en_d = 1'b1;
                        busy_d     = 1'b1;
                        len_d      = (seq_len > LEN_W'(MAX_LEN)) ?
                                     LEN_W'(MAX_LEN) : seq_len;
                    end
                end
            end
            SHOW, GAP: begin
                if (abort) begin
                    state_d    = IDLE;
                    leds_d     = '0;
                    timer_en_d = 1'b0;
                    busy_d     = 1'b0;
                end else if (timeout && state_q == SHOW) begin
                    state_d = GAP;
                    leds_d  = '0;
                end else if (timeout && last) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    timer_en_d = 1'b0;
                    busy_d     = 1'b0;
                end else if (timeout) begin
                    state_d = SHOW;
                    idx_d   = idx_q + IDX_W'(1);
                    leds_d  = 4'b0001 << rd_sym;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            leds_q     <= '0;
            timer_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            leds_q     <= leds_d;
            timer_en_q <= timer_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
        end
    end

    assign timer_en = timer_en_q;
    assign leds     = leds_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign play_idx = idx_q;

endmodule
